// File: rtl/fft_reorder_pp.sv
// fft_reorder_pp
//
// Ping-pong bit-reversal reorder buffer for the output of the parallel FFT.
// Frames of NFFT complex samples come in as LANES samples per beat in
// bit-reversed order. They leave in natural order over a valid/ready output.
// Two frame banks let consecutive frames stream at one beat per cycle. A
// per-frame bypass (sampled on the first beat) passes a frame through
// unreordered.
//
// Ports
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   flush              synchronous clear of both banks and the partial frame
//   bypass             frame mode, sampled on the first accepted beat
//   valid_in/in_ready  input beat handshake
//   din_i, din_q       input lanes, WIDTH-bit signed, [0:LANES-1]
//   valid_out/out_ready output beat handshake
//   dout_i, dout_q     output lanes, WIDTH-bit signed, [0:LANES-1]
//   sof_out, eof_out   first / last beat of the output frame
//   bypass_out         mode of the frame currently on the output
module fft_reorder_pp #(
  parameter int WIDTH = 13,
  parameter int LANES = 16,
  parameter int NFFT  = 512
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    bypass,
  input  logic                    valid_in,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] din_i [0:LANES-1],
  input  logic signed [WIDTH-1:0] din_q [0:LANES-1],
  output logic                    valid_out,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] dout_i [0:LANES-1],
  output logic signed [WIDTH-1:0] dout_q [0:LANES-1],
  output logic                    sof_out,
  output logic                    eof_out,
  output logic                    bypass_out
);

  localparam int LOG2N = $clog2(NFFT);
  localparam int BEATS = NFFT / LANES;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  // Frame storage, two banks; contents are intentionally not reset.
  logic signed [WIDTH-1:0] mem_i [0:1][0:NFFT-1];
  logic signed [WIDTH-1:0] mem_q [0:1][0:NFFT-1];

  logic [1:0]    full;
  logic [1:0]    byp;
  logic          wb;
  logic          rb;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;

  logic wr_fire;
  logic wr_last;
  logic wr_byp;
  logic rd_load;
  logic rd_last;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

  // Stream address of lane j within beat cnt.
  function automatic logic [LOG2N-1:0] lane_addr(input logic [CW-1:0] cnt,
                                                 input int unsigned j);
    return LOG2N'(cnt) * LOG2N'(LANES) + LOG2N'(j);
  endfunction

  assign in_ready = ~full[wb];
  assign wr_fire  = valid_in & in_ready & ~flush;
  assign wr_last  = wr_fire && (wr_cnt == LAST);
  // The first beat of a frame uses the live bypass input because byp[wb]
  // is only latched by that same beat.
  assign wr_byp   = (wr_cnt == '0) ? bypass : byp[wb];

  assign rd_load  = full[rb] & (~valid_out | out_ready) & ~flush;
  assign rd_last  = rd_load && (rd_cnt == LAST);

  // Write port: scatter each lane to its natural-order slot.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        if (wr_byp) begin
          mem_i[wb][lane_addr(wr_cnt, j)] <= din_i[j];
          mem_q[wb][lane_addr(wr_cnt, j)] <= din_q[j];
        end else begin
          mem_i[wb][bitrev(lane_addr(wr_cnt, j))] <= din_i[j];
          mem_q[wb][bitrev(lane_addr(wr_cnt, j))] <= din_q[j];
        end
      end
    end
  end

  // Output data register: contiguous read of the current beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        dout_i[j] <= '0;
        dout_q[j] <= '0;
      end
    end else if (rd_load) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        dout_i[j] <= mem_i[rb][lane_addr(rd_cnt, j)];
        dout_q[j] <= mem_q[rb][lane_addr(rd_cnt, j)];
      end
    end
  end

  // Bank bookkeeping and output flags. A write completing and a read
  // draining in the same cycle always target different banks (the write
  // needs !full[wb], the read needs full[rb]), so both updates of `full`
  // can be applied independently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full       <= '0;
      byp        <= '0;
      wb         <= 1'b0;
      rb         <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      valid_out  <= 1'b0;
      sof_out    <= 1'b0;
      eof_out    <= 1'b0;
      bypass_out <= 1'b0;
    end else if (flush) begin
      full      <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      valid_out <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) begin
          byp[wb] <= bypass;
        end
        if (wr_last) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          wr_cnt   <= '0;
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end

      if (rd_load) begin
        valid_out  <= 1'b1;
        sof_out    <= (rd_cnt == '0);
        eof_out    <= (rd_cnt == LAST);
        bypass_out <= byp[rb];
        if (rd_last) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
          rd_cnt   <= '0;
        end else begin
          rd_cnt <= rd_cnt + CW'(1);
        end
      end else if (out_ready) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder_pp.sv
module tb_fft_reorder_pp;

  localparam int WIDTH = 13;
  localparam int LANES = 16;
  localparam int NFFT  = 512;
  localparam int BEATS = NFFT / LANES;
  localparam int LOG2N = $clog2(NFFT);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic bypass = 1'b0;
  logic valid_in = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready;
  logic valid_out;
  logic sof_out, eof_out, bypass_out;
  logic signed [WIDTH-1:0] din_i  [0:LANES-1];
  logic signed [WIDTH-1:0] din_q  [0:LANES-1];
  logic signed [WIDTH-1:0] dout_i [0:LANES-1];
  logic signed [WIDTH-1:0] dout_q [0:LANES-1];

  fft_reorder_pp #(.WIDTH(WIDTH), .LANES(LANES), .NFFT(NFFT)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bypass(bypass),
    .valid_in(valid_in), .in_ready(in_ready), .din_i(din_i), .din_q(din_q),
    .valid_out(valid_out), .out_ready(out_ready),
    .dout_i(dout_i), .dout_q(dout_q),
    .sof_out(sof_out), .eof_out(eof_out), .bypass_out(bypass_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES-1:0][WIDTH-1:0] di;
    logic [LANES-1:0][WIDTH-1:0] dq;
    logic sof, eof, byp;
  } beat_t;

  beat_t exp_q[$];
  logic [WIDTH-1:0] fx_i [0:NFFT-1];
  logic [WIDTH-1:0] fx_q [0:NFFT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int unsigned ready_mode = 0;  // 0 hold low, 1 hold high, 2 random

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(1));
    endcase
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned rev(input int unsigned v);
    int unsigned r = 0;
    int unsigned x = v;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [LANES-1:0][WIDTH-1:0] flat_i();
    logic [LANES-1:0][WIDTH-1:0] f;
    for (int j = 0; j < LANES; j++) f[j] = dout_i[j];
    return f;
  endfunction

  function automatic logic [LANES-1:0][WIDTH-1:0] flat_q();
    logic [LANES-1:0][WIDTH-1:0] f;
    for (int j = 0; j < LANES; j++) f[j] = dout_q[j];
    return f;
  endfunction

  // Natural-order output n carries input stream sample rev(n) (or n in bypass).
  task automatic push_frame(input logic byp_mode);
    beat_t e;
    for (int k = 0; k < BEATS; k++) begin
      for (int j = 0; j < LANES; j++) begin
        int unsigned n = k * LANES + j;
        int unsigned src = byp_mode ? n : rev(n);
        e.di[j] = fx_i[src];
        e.dq[j] = fx_q[src];
      end
      e.sof = (k == 0);
      e.eof = (k == BEATS - 1);
      e.byp = byp_mode;
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_frame(input bit rnd);
    for (int a = 0; a < NFFT; a++) begin
      if (rnd) begin
        fx_i[a] = WIDTH'($urandom);
        fx_q[a] = WIDTH'($urandom);
      end else begin
        fx_i[a] = WIDTH'(a);
        fx_q[a] = WIDTH'(-a);
      end
    end
  endtask

  // Sends beats 0..nb-1 of the frame in fx; returns at posedge+1 after the
  // last acceptance with valid_in still driven. Stalls counts non-accepted
  // cycles with valid_in high.
  task automatic send_frame(input int nb, input logic byp_mode, input int gap_pct,
                            output int stalls);
    int k = 0;
    int tmo = 0;
    logic acc;
    stalls = 0;
    while (k < nb) begin
      if ($urandom_range(99) < gap_pct) begin
        valid_in = 1'b0;
      end else begin
        valid_in = 1'b1;
        bypass   = byp_mode;
        for (int j = 0; j < LANES; j++) begin
          din_i[j] = fx_i[k * LANES + j];
          din_q[j] = fx_q[k * LANES + j];
        end
      end
      acc = valid_in && in_ready;
      if (valid_in && !in_ready) stalls++;
      @(posedge clk); #1;
      if (acc) k++;
      else if (++tmo > 4000) begin
        chk("send_timeout", 256'(k), 256'(nb));
        return;
      end
    end
    if (nb == BEATS) push_frame(byp_mode);
  endtask

  task automatic drain();
    int t = 0;
    valid_in = 1'b0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || valid_out) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_done", 256'(exp_q.size() == 0 && !valid_out), 256'(1));
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_valid_out"}, 256'(valid_out), 256'(0));
    chk({tag, "_sof_eof_byp"}, 256'({sof_out, eof_out, bypass_out}), 256'(0));
    chk({tag, "_dout_i"}, 256'(flat_i()), 256'(0));
    chk({tag, "_dout_q"}, 256'(flat_q()), 256'(0));
    chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
  endtask

  // Scoreboard monitor: a beat transfers at the next edge when valid&ready.
  always @(negedge clk) begin
    if (rstn && valid_out && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 256'(flat_i()), 256'(0));
        if (flat_i() == '0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got beat with empty scoreboard, want none");
        end
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_i", 256'(flat_i()), 256'(e.di));
        chk("beat_q", 256'(flat_q()), 256'(e.dq));
        chk("beat_flags", 256'({sof_out, eof_out, bypass_out}), 256'({e.sof, e.eof, e.byp}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int t;
    int c0;
    int bad;
    beat_t held;

    for (int j = 0; j < LANES; j++) begin
      din_i[j] = '0;
      din_q[j] = '0;
    end

    // Reset state
    #3;
    reset_outputs_check("reset");
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    ready_mode = 1;
    @(posedge clk); #1;

    // Normal mode, ramp data, latency and first lanes
    fill_frame(0);
    send_frame(BEATS, 1'b0, 0, st);
    valid_in = 1'b0;
    chk("lat_not_yet", 256'(valid_out), 256'(0));
    @(posedge clk); #1;
    chk("lat_first_valid", 256'(valid_out), 256'(1));
    chk("lat_first_sof", 256'(sof_out), 256'(1));
    chk("lane0", 256'(dout_i[0]), 256'(0));
    chk("lane1", 256'(dout_i[1]), 256'(256));
    chk("lane2", 256'(dout_i[2]), 256'(128));
    chk("lane3", 256'(dout_i[3]), 256'(384));
    drain();

    // Three back-to-back frames: no stalls, 96 contiguous output beats
    fork
      begin
        int stt = 0;
        for (int f = 0; f < 3; f++) begin
          fill_frame(1);
          send_frame(BEATS, 1'b0, 0, st);
          stt += st;
        end
        valid_in = 1'b0;
        chk("b2b_no_stall", 256'(stt), 256'(0));
      end
      begin
        int tt = 0;
        bad = 0;
        @(negedge clk);
        while (!valid_out && tt < 500) begin
          @(negedge clk);
          tt++;
        end
        for (int i = 0; i < 3 * BEATS; i++) begin
          if (!valid_out) bad++;
          @(negedge clk);
        end
        chk("b2b_contiguous", 256'(bad), 256'(0));
      end
    join
    drain();

    // Backpressure: two frames stored, hold, then drain
    ready_mode = 0;
    @(posedge clk); #1;
    c0 = cyc;
    fill_frame(1);
    send_frame(BEATS, 1'b0, 0, st);
    fill_frame(1);
    send_frame(BEATS, 1'b1, 0, st);
    valid_in = 1'b0;
    chk("bp_cycles_64", 256'(cyc - c0), 256'(2 * BEATS));
    chk("bp_in_ready_low", 256'(in_ready), 256'(0));
    held = exp_q[0];
    chk("bp_hold_valid", 256'(valid_out), 256'(1));
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_hold_in_ready", 256'(in_ready), 256'(0));
    chk("bp_hold_valid2", 256'(valid_out), 256'(1));
    chk("bp_hold_data", 256'(flat_i()), 256'(held.di));
    chk("bp_hold_sof", 256'(sof_out), 256'(1));
    ready_mode = 1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_reassert_eof", 256'({in_ready, valid_out, eof_out}), 256'(3'b111));
    drain();

    // Normal frame then bypass frame with ramp data
    fill_frame(0);
    send_frame(BEATS, 1'b0, 0, st);
    send_frame(BEATS, 1'b1, 0, st);
    drain();

    // Random gaps and random backpressure
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      fill_frame(1);
      send_frame(BEATS, 1'($urandom_range(1)), 50, st);
    end
    drain();

    // Flush while frame 0 drains and frame 1 is 10 beats in
    fill_frame(1);
    send_frame(BEATS, 1'b0, 0, st);
    fill_frame(1);
    send_frame(10, 1'b0, 0, st);
    valid_in = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    chk("flush_valid_out", 256'(valid_out), 256'(0));
    chk("flush_in_ready", 256'(in_ready), 256'(1));
    fill_frame(1);
    send_frame(BEATS, 1'b0, 0, st);
    drain();

    // Reset mid-frame
    fill_frame(1);
    send_frame(BEATS, 1'b0, 0, st);
    send_frame(12, 1'b0, 0, st);
    valid_in = 1'b0;
    rstn = 1'b0;
    #2;
    exp_q.delete();
    reset_outputs_check("midrst");
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    fill_frame(1);
    send_frame(BEATS, 1'b1, 0, st);
    fill_frame(1);
    send_frame(BEATS, 1'b0, 0, st);
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
